pwm_output_stage: RTL and testbench
===================================

Name: pwm_output_stage

Overview:
- Downstream consumer of the SPI register block's five configuration registers. Drives 16 output pins.
- Each pin is one of three things: forced low, static high, or a shared PWM waveform.
- The shared waveform is an 8-bit duty cycle over a 256-tick period, with a prescaled tick.
- Sits between the SPI register file and the top-level uo_out/uio_out pin mux.

Parameters:
- PRESCALE, 3000, clk cycles per PWM tick; legal range 1..65535.
- PRESCALE_W, 16, width of the prescaler counter.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- en_reg_out_7_0  input  8  output enable, channels 7..0
- en_reg_out_15_8  input  8  output enable, channels 15..8
- en_reg_pwm_7_0  input  8  PWM select, channels 7..0
- en_reg_pwm_15_8  input  8  PWM select, channels 15..8
- pwm_duty_cycle  input  8  requested duty (0x00 = 0%, 0xFF = 100%)
- out  output  16  channel outputs; bits 7..0 go to uo_out, bits 15..8 go to uio_out
- period_start  output  1  one-cycle pulse on the first cycle of each PWM period

Behaviour:
- Clock and reset:
  - Single clock domain: clk. Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
  - Reset values: pre_cnt=0, pwm_cnt=0, duty_act=0, out=16'h0000, period_start=0.
  - rst asserted mid-period: all state takes reset values at the next edge. No partial-period completion.
- Prescaler:
  - pre_cnt counts 0..PRESCALE-1.
  - tick=1 when pre_cnt==PRESCALE-1; pre_cnt then returns to 0.
  - With PRESCALE=1, tick is asserted every cycle.
- Period counter:
  - pwm_cnt is 8 bits and increments on tick, wrapping 255->0.
  - Period = 256*PRESCALE clk cycles.
- Wrap:
  - wrap = tick && pwm_cnt==255.
  - period_start is registered and equals 1 in the cycle after the wrap edge, i.e. the first cycle with pwm_cnt==0.
- Duty compare (combinational on current state):
  - pwm_raw = 1 if duty_act==8'hFF; otherwise pwm_raw = (pwm_cnt < duty_act).
  - duty 0x00: never high. duty 0xFF: always high, no 1-tick gap. duty N: high for N ticks of 256.
- Channel i output, registered (1-cycle latency from any input change or counter state):
  - out[i] <= en_out[i] & (en_pwm[i] ? pwm_raw : 1'b1).
  - en_out = {en_reg_out_15_8, en_reg_out_7_0}; en_pwm likewise.
  - Enable registers are not shadowed; they take effect on the next edge, even mid-period.
- Duty update:
  - duty_act follows the Optional Feature rules below.
  - Simultaneous wrap and duty change: the pwm_duty_cycle value present at the wrap edge is captured.
- No handshake to the upstream block; inputs are level-held registers in the same clk domain.

Optional Feature:
- Macro: PWM_DUTY_SHADOW_EN.
- Defined:
  - duty_act loads pwm_duty_cycle only on wrap (and resets to 0).
  - Mid-period duty writes therefore take effect from the next period_start, giving glitch-free periods.
  - After reset, the first period always runs at duty 0.
- Undefined:
  - duty_act is a plain register loaded from pwm_duty_cycle every cycle (1-cycle latency).
  - Mid-period changes alter the current period immediately.

Decomposition:
- Package pwm_pkg:
  - NUM_CH=16, PWM_CNT_W=8, DUTY_FULL=8'hFF.
  - Typedef ch_vec_t (logic [NUM_CH-1:0]).
  - Typedef duty_t (logic [PWM_CNT_W-1:0]).
- One sub-module, pwm_prescaler:
  - Parameter PRESCALE.
  - Ports clk, rst, tick.
  - Owns pre_cnt.
- The top module holds pwm_cnt, duty_act, the compare, and the output registers.

Test Plan (bench uses PRESCALE=4, so period = 1024 cycles):
- Reset:
  - Stimulus: hold rst 3 cycles with all inputs 0xFF.
  - Required: out=0x0000 and period_start=0 throughout. First period_start appears 1024 cycles after rst deasserts.
- Static enable:
  - Stimulus: en_out=0xFFFF, en_pwm=0x0000, duty=0x00.
  - Required: out=0xFFFF one cycle after the inputs settle. Then en_out=0x00F0 gives out=0x00F0 on the next cycle.
- 50% PWM:
  - Stimulus: en_out=en_pwm=0x0001, duty=0x80, with shadow defined.
  - Required: from the second period_start, out[0] is high 512 cycles then low 512 cycles per period. Other bits stay 0.
- Extremes:
  - duty=0x00 gives out[0] low all 1024 cycles.
  - duty=0xFF gives out[0] high all 1024 cycles with no gap at the wrap.
- Mid-period change, shadow defined:
  - Stimulus: duty 0x40->0xC0 at pwm_cnt=0x10.
  - Required: the current period stays high 256 cycles; the next period is high 768 cycles.
- Mid-period reset:
  - Stimulus: assert rst at pwm_cnt=0x55 with out[0]=1.
  - Required: next cycle out=0, pwm_cnt=0, pre_cnt=0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM output stage.
package pwm_pkg;

  localparam int unsigned NUM_CH    = 16;
  localparam int unsigned PWM_CNT_W = 8;

  typedef logic [NUM_CH-1:0]    ch_vec_t;
  typedef logic [PWM_CNT_W-1:0] duty_t;

  localparam duty_t DUTY_FULL = 8'hFF;
  localparam duty_t CNT_LAST  = 8'hFF;

  // Full-scale duty is special-cased so 0xFF has no one-tick low gap at the wrap.
  function automatic logic duty_compare(input duty_t cnt, input duty_t duty);
    return (duty == DUTY_FULL) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Prescaler for the PWM stage: emits a one-cycle tick every PRESCALE clk cycles.
module pwm_prescaler #(
  parameter int unsigned PRESCALE   = 3000,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [PRESCALE_W-1:0] PreLast = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;

  assign tick = (pre_cnt_q == PreLast);

  // Count 0..PRESCALE-1, returning to zero on the tick cycle.
  always_comb begin
    pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
    if (tick) begin
      pre_cnt_d = '0;
    end
  end

  // Prescaler state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/pwm_output_stage.sv
// PWM output stage: 16 channels, each forced low, static high or driven by a
// shared 8-bit PWM waveform over a 256-tick period.
// Optional macro PWM_DUTY_SHADOW_EN: duty is only latched at the period wrap.
module pwm_output_stage
  import pwm_pkg::*;
#(
  parameter int unsigned PRESCALE   = 3000,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        en_reg_out_7_0,
  input  logic [7:0]        en_reg_out_15_8,
  input  logic [7:0]        en_reg_pwm_7_0,
  input  logic [7:0]        en_reg_pwm_15_8,
  input  logic [7:0]        pwm_duty_cycle,
  output logic [NUM_CH-1:0] out,
  output logic              period_start
);

  logic    tick;
  logic    wrap;
  logic    pwm_raw;
  duty_t   pwm_cnt_q, pwm_cnt_d;
  duty_t   duty_act_q, duty_act_d;
  ch_vec_t en_out, en_pwm;
  ch_vec_t out_q, out_d;
  logic    period_start_q;

  pwm_prescaler #(
    .PRESCALE   (PRESCALE),
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign en_out  = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign wrap    = tick && (pwm_cnt_q == CNT_LAST);
  assign pwm_raw = duty_compare(pwm_cnt_q, duty_act_q);

  // Next-state for the period counter, active duty and channel outputs.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q;
    if (tick) begin
      pwm_cnt_d = pwm_cnt_q + duty_t'(1);
    end

`ifdef PWM_DUTY_SHADOW_EN
    // Duty only changes at the wrap so every period is glitch-free.
    duty_act_d = duty_act_q;
    if (wrap) begin
      duty_act_d = pwm_duty_cycle;
    end
`else
    duty_act_d = pwm_duty_cycle;
`endif

    // PWM-selected channels follow the waveform, others are static high.
    out_d = en_out & (~en_pwm | {NUM_CH{pwm_raw}});
  end

  // Counter, duty and registered output state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q      <= '0;
      duty_act_q     <= '0;
      out_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      pwm_cnt_q      <= pwm_cnt_d;
      duty_act_q     <= duty_act_d;
      out_q          <= out_d;
      period_start_q <= wrap;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_output_stage.sv
// Self-checking bench for pwm_output_stage with PRESCALE=4 (1024-cycle period).
module tb_pwm_output_stage;

  localparam int unsigned PRESCALE = 4;
  localparam int unsigned PERIOD   = 256 * PRESCALE;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  en_reg_out_7_0, en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  int errors = 0;
  int checks = 0;

  // Scoreboard entries are {period_start, out}.
  logic [16:0] exp_q[$];

  pwm_output_stage #(
    .PRESCALE   (PRESCALE),
    .PRESCALE_W (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .out             (out),
    .period_start    (period_start)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic set_inputs(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    {en_reg_out_15_8, en_reg_out_7_0} = eo;
    {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
    pwm_duty_cycle = d;
  endtask

  // Advance to the next negedge sample where period_start is high.
  task automatic wait_ps(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < PERIOD + 16; i++) begin
      @(negedge clk);
      if (period_start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: period_start not seen within %0d cycles", tag, PERIOD + 16);
    end
  endtask

  // Expected out[0] k samples after period_start, given a duty held for two periods.
  function automatic logic exp_bit(input int k, input logic [7:0] d);
    if (d == 8'hFF) return 1'b1;
    if (k == 0) return 1'b0;
    return ((k - 1) / PRESCALE) < int'(d);
  endfunction

  // Called at the negedge where period_start is high; checks the whole period.
  task automatic check_period(input string tag, input logic [7:0] d, input logic [15:0] en);
    logic [16:0] e;
    int highs = 0;
    int exp_highs;
    exp_q.push_back({1'b1, en & {16{exp_bit(0, d)}}});
    for (int k = 0; k < int'(PERIOD); k++) begin
      e = exp_q.pop_front();
      checks++;
      if ({period_start, out} !== e) begin
        errors++;
        $display("FAIL %s k=%0d: got ps=%b out=%h, want ps=%b out=%h",
                 tag, k, period_start, out, e[16], e[15:0]);
      end
      if (out[0]) highs++;
      if (k < int'(PERIOD) - 1) begin
        exp_q.push_back({1'b0, en & {16{exp_bit(k + 1, d)}}});
        @(negedge clk);
      end
    end
    exp_highs = (d == 8'hFF) ? int'(PERIOD) : int'(PRESCALE) * int'(d);
    checks++;
    if (highs != exp_highs) begin
      errors++;
      $display("FAIL %s high_count: got %0d, want %0d", tag, highs, exp_highs);
    end
  endtask

  task automatic test_reset();
    int n = 0;
    rst = 1'b1;
    set_inputs(16'hFFFF, 16'hFFFF, 8'hFF);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({period_start, out} !== 17'h0) begin
        errors++;
        $display("FAIL reset_hold: got ps=%b out=%h, want ps=0 out=0000", period_start, out);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < int'(PERIOD) + 16; i++) begin
      @(negedge clk);
      n++;
      if (period_start) break;
    end
    checks++;
    if (n != int'(PERIOD)) begin
      errors++;
      $display("FAIL reset_first_ps: got %0d cycles, want %0d", n, PERIOD);
    end
  endtask

  task automatic test_static_enable();
    logic [15:0] pats[5] = '{16'hFFFF, 16'h00F0, 16'hA5C3, 16'h0001, 16'h0000};
    logic [16:0] e;
    foreach (pats[i]) begin
      set_inputs(pats[i], 16'h0000, 8'h00);
      exp_q.push_back({1'b0, pats[i]});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (out !== e[15:0]) begin
        errors++;
        $display("FAIL static_%0d: got out=%h, want %h", i, out, e[15:0]);
      end
    end
  endtask

  task automatic test_pwm50();
    set_inputs(16'h0001, 16'h0001, 8'h80);
    wait_ps("pwm50_sync0");
    wait_ps("pwm50_sync1");
    check_period("pwm50", 8'h80, 16'h0001);
  endtask

  task automatic test_extremes();
    set_inputs(16'h0001, 16'h0001, 8'h00);
    wait_ps("duty00_sync0");
    wait_ps("duty00_sync1");
    check_period("duty00", 8'h00, 16'h0001);
    set_inputs(16'h0001, 16'h0001, 8'hFF);
    wait_ps("dutyFF_sync0");
    wait_ps("dutyFF_sync1");
    check_period("dutyFF", 8'hFF, 16'h0001);
  endtask

  task automatic test_mid_change();
    int  highs = 0;
    bit  changed = 1'b0;
    int  exp_cur;
`ifdef PWM_DUTY_SHADOW_EN
    exp_cur = 256;
`else
    exp_cur = 768;
`endif
    set_inputs(16'h0001, 16'h0001, 8'h40);
    wait_ps("midchg_sync0");
    wait_ps("midchg_sync1");
    for (int k = 0; k < int'(PERIOD); k++) begin
      if (k > 0) @(negedge clk);
      if (out[0]) highs++;
      if (!changed && dut.pwm_cnt_q == 8'h10) begin
        pwm_duty_cycle = 8'hC0;
        changed = 1'b1;
      end
    end
    checks++;
    if (highs != exp_cur) begin
      errors++;
      $display("FAIL midchg_current: got %0d high cycles, want %0d", highs, exp_cur);
    end
    @(negedge clk);
    checks++;
    if (period_start !== 1'b1) begin
      errors++;
      $display("FAIL midchg_wrap: got ps=%b, want 1", period_start);
    end
    check_period("midchg_next", 8'hC0, 16'h0001);
  endtask

  task automatic test_mid_reset();
    bit found = 1'b0;
    int n = 0;
    set_inputs(16'h0001, 16'h0001, 8'h80);
    wait_ps("midrst_sync0");
    wait_ps("midrst_sync1");
    for (int i = 0; i < int'(PERIOD); i++) begin
      @(negedge clk);
      if (dut.pwm_cnt_q == 8'h55 && out[0]) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midrst_find: got no cycle at pwm_cnt=55 with out[0]=1, want one");
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({period_start, out} !== 17'h0) begin
      errors++;
      $display("FAIL midrst_out: got ps=%b out=%h, want ps=0 out=0000", period_start, out);
    end
    checks++;
    if (dut.pwm_cnt_q !== 8'h00) begin
      errors++;
      $display("FAIL midrst_pwm_cnt: got %h, want 00", dut.pwm_cnt_q);
    end
    checks++;
    if (dut.u_prescaler.pre_cnt_q !== 16'h0000) begin
      errors++;
      $display("FAIL midrst_pre_cnt: got %h, want 0000", dut.u_prescaler.pre_cnt_q);
    end
    rst = 1'b0;
    for (int i = 0; i < int'(PERIOD) + 16; i++) begin
      @(negedge clk);
      n++;
      if (period_start) break;
    end
    checks++;
    if (n != int'(PERIOD)) begin
      errors++;
      $display("FAIL midrst_next_ps: got %0d cycles, want %0d", n, PERIOD);
    end
  endtask

  initial begin
    test_reset();
    test_static_enable();
    test_pwm50();
    test_extremes();
    test_mid_change();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
